cp0_access_unit: RTL and testbench
==================================

# cp0_access_unit

Execute-side consumer of the decode-stage CP0 read/write flags and 8-bit CP0 address. Holds one CP0 operation at a time and waits until its ROB entry is the oldest in flight. Then performs exactly one access on the CP0 register-file port and returns the result on a valid/ready result bus. This serialises all MFC0/MTC0 traffic so CP0 state is never touched speculatively.

## Interface
- ROB_ID_W, 5, width of ROB entry tag
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush; discards any held speculative op
- issue_valid  in  1  CP0 op offered
- issue_ready  out  1  unit can accept an op
- issue_rob_id  in  ROB_ID_W  ROB tag of the op
- issue_read  in  1  MFC0 (cp0_read_flag from decode)
- issue_write  in  1  MTC0 (cp0_write_flag from decode)
- issue_addr  in  8  CP0 address {rd[4:0], sel[2:0]}
- issue_wdata  in  32  GPR value to write (MTC0)
- rob_head_valid  in  1  ROB head entry valid
- rob_head_id  in  ROB_ID_W  ROB head tag
- cp0_re  out  1  CP0 read strobe
- cp0_we  out  1  CP0 write strobe
- cp0_addr  out  8  CP0 port address
- cp0_wdata  out  32  CP0 write data
- cp0_rdata  in  32  CP0 read data, combinational from cp0_addr
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result_rob_id  out  ROB_ID_W  tag of completed op
- result_data  out  32  MFC0 data; 0 for MTC0/no-op
- busy  out  1  unit holds an op; decode stalls further CP0 ops

## Operation
- FSM states: IDLE, WAIT_HEAD, ACCESS, DONE.
- IDLE
  - issue_ready = 1 when flush = 0.
  - On issue_valid && issue_ready, latch rob_id, read, write, addr and wdata, then go to WAIT_HEAD.
  - write = 1 takes priority: the latched read flag is cleared when both flags are set.
- WAIT_HEAD
  - When rob_head_valid && rob_head_id == held tag: go to ACCESS if read or write is set.
  - Neither flag set: go straight to DONE with data 0.
  - Otherwise stay in WAIT_HEAD.
- ACCESS (exactly 1 cycle)
  - Drive cp0_addr = held addr.
  - Write op: cp0_we = 1 and cp0_wdata = held wdata.
  - Read op: cp0_re = 1, and cp0_rdata is captured into the result register at the clock edge.
  - Write op: result register = 0.
  - Next state is DONE.
- DONE: result_valid = 1 with result_rob_id and result_data stable. On result_ready go to IDLE.
- busy = (state != IDLE).
- Outside ACCESS: cp0_re = cp0_we = 0, cp0_addr = 0, cp0_wdata = 0.
- flush
  - In IDLE: nothing is accepted that cycle.
  - In WAIT_HEAD or DONE: op dropped, go to IDLE, no CP0 strobe ever issued.
  - In ACCESS: the strobe still completes because the op is at ROB head and therefore committed. The next state is IDLE, not DONE, and no result is produced.
- A flush takes precedence over a simultaneous head match or result_ready.

## Timing
- Reset (rst = 0 at clock edge): state IDLE.
  - Outputs: issue_ready = 1 after reset deasserts; result_valid = 0, cp0_re = 0, cp0_we = 0, busy = 0.
  - Registers: cp0_addr = 0, cp0_wdata = 0, result_data = 0, result_rob_id = 0.
  - Reset mid-operation aborts the op immediately, including in ACCESS: no strobe is asserted in the cycle after reset.
- Minimum latency, with head matching on the first WAIT_HEAD cycle:
  - Accept at cycle N.
  - WAIT_HEAD at N+1.
  - ACCESS (strobe) at N+2.
  - result_valid at N+3.
  - IDLE and issue_ready at N+4 if result_ready = 1 at N+3.
- Each accepted op produces at most one cp0_we/cp0_re pulse, exactly one cycle wide.
- result_valid holds with unchanged payload until result_ready is sampled high.

## Test plan
- MFC0 path: issue read, addr 0x60 (Status), rob_id 3; hold rob_head_id = 3; cp0_rdata = 0x0040FF01.
  - Required: cp0_re pulse at N+2 with cp0_addr = 0x60.
  - Required: result_valid at N+3 with data 0x0040FF01, tag 3.
- MTC0 path: issue write, addr 0x68 (Cause), wdata 0x00000300; head = tag.
  - Required: single cp0_we pulse with cp0_wdata = 0x300.
  - Required: result data 0, cp0_re never asserted.
- Head wait: rob_head_id ≠ tag for 10 cycles, then matches.
  - Required: no strobe and busy = 1 during the wait.
  - Required: strobe one cycle after the match.
- Flush in WAIT_HEAD: flush asserted before head matches.
  - Required: no strobe, no result_valid, IDLE next cycle, new op accepted.
- Flush in ACCESS: flush asserted in the strobe cycle.
  - Required: strobe completes, no result_valid, IDLE next cycle.
- Back-pressure plus reset:
  - result_ready = 0 for 5 cycles: result held stable and issue_ready = 0 throughout.
  - Then rst = 0: all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/cp0_access_unit.sv
// Serialises MFC0/MTC0 traffic: holds one CP0 op until it is the oldest ROB entry,
// performs a single CP0 port access, then returns the result on a valid/ready bus.
module cp0_access_unit #(
  parameter int ROB_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ROB_ID_W-1:0] issue_rob_id,
  input  logic                issue_read,
  input  logic                issue_write,
  input  logic [7:0]          issue_addr,
  input  logic [31:0]         issue_wdata,
  input  logic                rob_head_valid,
  input  logic [ROB_ID_W-1:0] rob_head_id,
  output logic                cp0_re,
  output logic                cp0_we,
  output logic [7:0]          cp0_addr,
  output logic [31:0]         cp0_wdata,
  input  logic [31:0]         cp0_rdata,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [ROB_ID_W-1:0] result_rob_id,
  output logic [31:0]         result_data,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, WAIT_HEAD, ACCESS, DONE} state_t;

  state_t              state;
  state_t              next_state;
  logic [ROB_ID_W-1:0] held_rob_id;
  logic                held_read;
  logic                held_write;
  logic [7:0]          held_addr;
  logic [31:0]         held_wdata;
  logic                head_match;

  assign head_match = rob_head_valid && (rob_head_id == held_rob_id);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Flush wins over a head match or result_ready; an ACCESS already at the head
  // still strobes but is not reported.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (issue_valid && !flush) next_state = WAIT_HEAD;
      end
      WAIT_HEAD: begin
        if (flush)                          next_state = IDLE;
        else if (head_match)                next_state = (held_read || held_write) ? ACCESS : DONE;
      end
      ACCESS: begin
        next_state = flush ? IDLE : DONE;
      end
      DONE: begin
        if (flush || result_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      held_rob_id   <= '0;
      held_read     <= 1'b0;
      held_write    <= 1'b0;
      held_addr     <= '0;
      held_wdata    <= '0;
      result_rob_id <= '0;
      result_data   <= '0;
    end else begin
      if (state == IDLE && issue_valid && issue_ready) begin
        held_rob_id <= issue_rob_id;
        held_read   <= issue_read && !issue_write;
        held_write  <= issue_write;
        held_addr   <= issue_addr;
        held_wdata  <= issue_wdata;
      end
      if (state == WAIT_HEAD && !flush && head_match && !held_read && !held_write) begin
        result_rob_id <= held_rob_id;
        result_data   <= '0;
      end
      if (state == ACCESS && !flush) begin
        result_rob_id <= held_rob_id;
        result_data   <= held_read ? cp0_rdata : 32'd0;
      end
    end
  end

  always_comb begin
    issue_ready  = (state == IDLE) && !flush;
    busy         = (state != IDLE);
    result_valid = (state == DONE);
    cp0_re       = 1'b0;
    cp0_we       = 1'b0;
    cp0_addr     = '0;
    cp0_wdata    = '0;
    if (state == ACCESS) begin
      cp0_re    = held_read;
      cp0_we    = held_write;
      cp0_addr  = held_addr;
      cp0_wdata = held_write ? held_wdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_cp0_access_unit.sv
// Directed bench for cp0_access_unit: table of single ops plus hand-written
// sequences for head wait, flush, back-pressure and reset corner cases.
module tb_cp0_access_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rob_id;
  logic        issue_read;
  logic        issue_write;
  logic [7:0]  issue_addr;
  logic [31:0] issue_wdata;
  logic        rob_head_valid;
  logic [4:0]  rob_head_id;
  logic        cp0_re;
  logic        cp0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        result_valid;
  logic        result_ready;
  logic [4:0]  result_rob_id;
  logic [31:0] result_data;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [4:0]  rob_id;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_access;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  cp0_access_unit #(.ROB_ID_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rob_id(issue_rob_id),
    .issue_read(issue_read), .issue_write(issue_write), .issue_addr(issue_addr),
    .issue_wdata(issue_wdata), .rob_head_valid(rob_head_valid), .rob_head_id(rob_head_id),
    .cp0_re(cp0_re), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .result_valid(result_valid), .result_ready(result_ready),
    .result_rob_id(result_rob_id), .result_data(result_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] id, input logic rd, input logic wr,
                               input logic [7:0] addr, input logic [31:0] wdata);
    issue_valid  = 1'b1;
    issue_rob_id = id;
    issue_read   = rd;
    issue_write  = wr;
    issue_addr   = addr;
    issue_wdata  = wdata;
  endtask

  task automatic clearIssue();
    issue_valid = 1'b0;
    issue_read  = 1'b0;
    issue_write = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;
  endtask

  // One op with the head already matching: accept, WAIT_HEAD, [ACCESS], DONE, IDLE.
  task automatic runVector(input vec_t v);
    rob_head_valid = 1'b1;
    rob_head_id    = v.rob_id;
    cp0_rdata      = v.rdata;
    applyStimulus(v.rob_id, v.rd, v.wr, v.addr, v.wdata);
    #1;
    checkOutput("issue_ready_idle", issue_ready, 1);
    tick();
    clearIssue();
    #1;
    checkOutput("busy_wait_head", busy, 1);
    checkOutput("no_strobe_wait", {cp0_re, cp0_we}, 0);
    if (v.exp_access) begin
      tick();
      checkOutput("access_re", cp0_re, v.exp_re);
      checkOutput("access_we", cp0_we, v.exp_we);
      checkOutput("access_addr", cp0_addr, v.addr);
      checkOutput("access_wdata", cp0_wdata, v.exp_we ? v.wdata : 32'd0);
      checkOutput("access_no_valid", result_valid, 0);
    end
    tick();
    checkOutput("done_valid", result_valid, 1);
    checkOutput("done_data", result_data, v.exp_data);
    checkOutput("done_tag", result_rob_id, v.rob_id);
    checkOutput("done_no_strobe", {cp0_re, cp0_we}, 0);
    checkOutput("done_addr_zero", cp0_addr, 0);
    checkOutput("done_issue_ready", issue_ready, 0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    #1;
    checkOutput("back_idle_valid", result_valid, 0);
    checkOutput("back_idle_busy", busy, 0);
    checkOutput("back_idle_ready", issue_ready, 1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    flush = 1'b0;
    clearIssue();
    issue_rob_id = '0;
    rob_head_valid = 1'b0;
    rob_head_id = '0;
    cp0_rdata = '0;
    result_ready = 1'b0;

    vecs[0] = '{rob_id:5'd3,  rd:1'b1, wr:1'b0, addr:8'h60, wdata:32'h0,        rdata:32'h0040FF01,
                exp_access:1'b1, exp_re:1'b1, exp_we:1'b0, exp_data:32'h0040FF01};
    vecs[1] = '{rob_id:5'd7,  rd:1'b0, wr:1'b1, addr:8'h68, wdata:32'h00000300, rdata:32'hDEADBEEF,
                exp_access:1'b1, exp_re:1'b0, exp_we:1'b1, exp_data:32'h0};
    vecs[2] = '{rob_id:5'd12, rd:1'b1, wr:1'b1, addr:8'h10, wdata:32'hA5A5A5A5, rdata:32'h12345678,
                exp_access:1'b1, exp_re:1'b0, exp_we:1'b1, exp_data:32'h0};
    vecs[3] = '{rob_id:5'd31, rd:1'b0, wr:1'b0, addr:8'h20, wdata:32'h11111111, rdata:32'hFFFFFFFF,
                exp_access:1'b0, exp_re:1'b0, exp_we:1'b0, exp_data:32'h0};

    tick();
    tick();
    checkOutput("reset_valid", result_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_strobes", {cp0_re, cp0_we}, 0);
    checkOutput("reset_data", result_data, 0);
    checkOutput("reset_tag", result_rob_id, 0);
    rst = 1'b1;
    #1;
    checkOutput("reset_issue_ready", issue_ready, 1);
    tick();

    for (int i = 0; i < 4; i++) runVector(vecs[i]);

    // Head wait: mismatched head for 10 cycles, then match.
    rob_head_valid = 1'b1;
    rob_head_id    = 5'd0;
    cp0_rdata      = 32'h0000BEEF;
    applyStimulus(5'd9, 1'b1, 1'b0, 8'h08, 32'h0);
    tick();
    clearIssue();
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("wait_busy", busy, 1);
      checkOutput("wait_no_strobe", {cp0_re, cp0_we}, 0);
      checkOutput("wait_no_valid", result_valid, 0);
    end
    rob_head_id = 5'd9;
    tick();
    checkOutput("wait_strobe_after_match", cp0_re, 1);
    checkOutput("wait_strobe_addr", cp0_addr, 8'h08);
    tick();
    checkOutput("wait_result", result_data, 32'h0000BEEF);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Flush in WAIT_HEAD, coinciding with a head match.
    rob_head_id = 5'd0;
    applyStimulus(5'd4, 1'b0, 1'b1, 8'h68, 32'h00000300);
    tick();
    clearIssue();
    flush = 1'b1;
    rob_head_id = 5'd4;
    #1;
    checkOutput("flush_blocks_issue_ready", issue_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flushw_busy", busy, 0);
    checkOutput("flushw_no_strobe", {cp0_re, cp0_we}, 0);
    checkOutput("flushw_no_valid", result_valid, 0);
    checkOutput("flushw_issue_ready", issue_ready, 1);
    tick();
    checkOutput("flushw_still_no_strobe", {cp0_re, cp0_we}, 0);
    runVector('{rob_id:5'd5, rd:1'b1, wr:1'b0, addr:8'h78, wdata:32'h0, rdata:32'h00ABCDEF,
                exp_access:1'b1, exp_re:1'b1, exp_we:1'b0, exp_data:32'h00ABCDEF});

    // Flush in ACCESS: strobe completes, no result.
    rob_head_id = 5'd6;
    cp0_rdata = 32'hCAFE0001;
    applyStimulus(5'd6, 1'b1, 1'b0, 8'h60, 32'h0);
    tick();
    clearIssue();
    tick();
    flush = 1'b1;
    #1;
    checkOutput("flusha_strobe", cp0_re, 1);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flusha_no_valid", result_valid, 0);
    checkOutput("flusha_busy", busy, 0);
    checkOutput("flusha_no_strobe", cp0_re, 0);
    checkOutput("flusha_issue_ready", issue_ready, 1);
    tick();
    checkOutput("flusha_no_valid_later", result_valid, 0);

    // Reset during ACCESS aborts the strobe.
    rob_head_id = 5'd8;
    applyStimulus(5'd8, 1'b0, 1'b1, 8'h30, 32'h5555AAAA);
    tick();
    clearIssue();
    tick();
    checkOutput("rsta_strobe", cp0_we, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rsta_no_strobe", cp0_we, 0);
    checkOutput("rsta_busy", busy, 0);
    checkOutput("rsta_no_valid", result_valid, 0);

    // Back-pressure, then reset while the result is held.
    rob_head_id = 5'd2;
    cp0_rdata = 32'h11223344;
    applyStimulus(5'd2, 1'b1, 1'b0, 8'h60, 32'h0);
    tick();
    clearIssue();
    tick();
    tick();
    cp0_rdata = 32'h99999999;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", result_valid, 1);
      checkOutput("bp_data", result_data, 32'h11223344);
      checkOutput("bp_tag", result_rob_id, 5'd2);
      checkOutput("bp_issue_ready", issue_ready, 0);
      tick();
    end
    rst = 1'b0;
    tick();
    checkOutput("bpr_valid", result_valid, 0);
    checkOutput("bpr_busy", busy, 0);
    checkOutput("bpr_strobes", {cp0_re, cp0_we}, 0);
    checkOutput("bpr_addr", cp0_addr, 0);
    checkOutput("bpr_wdata", cp0_wdata, 0);
    checkOutput("bpr_data", result_data, 0);
    checkOutput("bpr_tag", result_rob_id, 0);
    rst = 1'b1;
    #1;
    checkOutput("bpr_issue_ready", issue_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
